sync_fifo_flags: RTL and testbench



---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_wrap_ptr.sv | 36 +++
 rtl/sync_fifo_flags.sv | 122 ++++++++++++
 tb/tb_sync_fifo_flags.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helper for the flagged synchronous FIFO.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DATA_DEPTH = 8;

    // Width of a counter that must hold every value 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Storage-index pointer that wraps at DEPTH-1, so DEPTH need not be a power of two.
module fifo_wrap_ptr
    import fifo_pkg::*;
#(
    parameter int   DEPTH = DEF_DATA_DEPTH,
    localparam int  PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with fill level, almost-full/empty thresholds and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  DATA_DEPTH = DEF_DATA_DEPTH,
    parameter int  AF_LEVEL   = 6,
    parameter int  AE_LEVEL   = 2,
    localparam int CNT_W      = cnt_w(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_W-1:0]      fill_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int               PTR_W   = $clog2(DATA_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DATA_DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic                  empty_q;
    logic                  full_q;
    logic                  af_q;
    logic                  ae_q;
    logic                  ovf_q;
    logic                  unf_q;

    // A write into a full FIFO is still taken when a read frees a slot in the same cycle.
    always_comb begin
        rd_ok   = rd_en & ~empty_q;
        wr_ok   = wr_en & (~full_q | rd_ok);
        count_d = count_q;
        if (wr_ok && !rd_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == DEPTH_C);
            af_q    <= (count_d >= AF_C);
            ae_q    <= (count_d <= AE_C);
            ovf_q   <= wr_en & ~wr_ok;
            unf_q   <= rd_en & ~rd_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr] <= data_in;
        end
    end

    fifo_wrap_ptr #(.DEPTH(DATA_DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wr_ok),
        .ptr   (wr_ptr)
    );

    fifo_wrap_ptr #(.DEPTH(DATA_DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rd_ok),
        .ptr   (rd_ptr)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign data_out = mem_q[rd_ptr];
`else
    logic [DATA_WIDTH-1:0] dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else if (rd_ok) begin
            dout_q <= mem_q[rd_ptr];
        end
    end

    assign data_out = dout_q;
`endif

    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign fill_count   = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: depth-8 and depth-5 instances checked every cycle against a queue model.
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] wr = '0;
    logic [1:0] rd = '0;
    logic [7:0] din  [2] = '{8'h00, 8'h00};
    logic [7:0] dout [2];
    logic [1:0] emp, ful, af, ae, ovf, unf;
    logic [3:0] fc0;
    logic [2:0] fc1;
    logic [3:0] fcnt [2];

    int tests = 0;
    int fails = 0;

    localparam int DEP [2] = '{8, 5};
    localparam int AFL [2] = '{6, 4};
    localparam int AEL [2] = '{2, 1};

    logic [7:0] mq [2][$];
    logic [7:0] exp_dout [2] = '{8'h00, 8'h00};
    logic [1:0] exp_ovf = '0;
    logic [1:0] exp_unf = '0;

    always #5 clk = ~clk;

    assign fcnt[0] = fc0;
    assign fcnt[1] = {1'b0, fc1};

    sync_fifo_flags #(.DATA_WIDTH(8), .DATA_DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr[0]), .data_in(din[0]), .rd_en(rd[0]),
        .data_out(dout[0]), .empty(emp[0]), .full(ful[0]), .almost_full(af[0]),
        .almost_empty(ae[0]), .fill_count(fc0), .overflow(ovf[0]), .underflow(unf[0])
    );

    sync_fifo_flags #(.DATA_WIDTH(8), .DATA_DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr[1]), .data_in(din[1]), .rd_en(rd[1]),
        .data_out(dout[1]), .empty(emp[1]), .full(ful[1]), .almost_full(af[1]),
        .almost_empty(ae[1]), .fill_count(fc1), .overflow(ovf[1]), .underflow(unf[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a FIFO is a queue; acceptance follows directly from its size.
    always @(posedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                int n;
                bit rok, wok;
                n   = mq[k].size();
                rok = rd[k] && (n > 0);
                wok = wr[k] && ((n < DEP[k]) || rok);
                exp_ovf[k] = wr[k] && !wok;
                exp_unf[k] = rd[k] && !rok;
                if (rok) exp_dout[k] = mq[k].pop_front();
                if (wok) mq[k].push_back(din[k]);
            end
        end
    end

    always @(negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            exp_dout[k] = 8'h00;
        end
        exp_ovf = '0;
        exp_unf = '0;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                int n;
                n = mq[k].size();
                chk($sformatf("m%0d_count", k), fcnt[k], n);
                chk($sformatf("m%0d_empty", k), emp[k], n == 0);
                chk($sformatf("m%0d_full", k), ful[k], n == DEP[k]);
                chk($sformatf("m%0d_afull", k), af[k], n >= AFL[k]);
                chk($sformatf("m%0d_aempty", k), ae[k], n <= AEL[k]);
                chk($sformatf("m%0d_ovf", k), ovf[k], exp_ovf[k]);
                chk($sformatf("m%0d_unf", k), unf[k], exp_unf[k]);
`ifdef SYNC_FIFO_FWFT_EN
                if (n > 0) chk($sformatf("m%0d_dout", k), dout[k], mq[k][0]);
`else
                chk($sformatf("m%0d_dout", k), dout[k], exp_dout[k]);
`endif
            end
        end
    end

    task automatic drive(input int k, input bit w, input logic [7:0] d, input bit r);
        wr     = '0;
        rd     = '0;
        wr[k]  = w;
        rd[k]  = r;
        din[k] = d;
        @(negedge clk);
    endtask

    task automatic pop_chk(input int k, input string nm, input logic [7:0] e);
`ifdef SYNC_FIFO_FWFT_EN
        chk(nm, dout[k], e);
        drive(k, 1'b0, 8'h00, 1'b1);
`else
        drive(k, 1'b0, 8'h00, 1'b1);
        chk(nm, dout[k], e);
`endif
    endtask

    task automatic reset_lits(input string nm);
        chk({nm, "_count"}, fc0, 0);
        chk({nm, "_empty"}, emp[0], 1);
        chk({nm, "_aempty"}, ae[0], 1);
        chk({nm, "_full"}, ful[0], 0);
        chk({nm, "_afull"}, af[0], 0);
        chk({nm, "_ovf"}, ovf[0], 0);
        chk({nm, "_unf"}, unf[0], 0);
`ifndef SYNC_FIFO_FWFT_EN
        chk({nm, "_dout"}, dout[0], 8'h00);
`endif
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_lits("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Fill depth-8 instance: 0x11..0x88
        for (int i = 0; i < 8; i++) begin
            drive(0, 1'b1, 8'(8'h11 * (i + 1)), 1'b0);
            chk("t1_count", fc0, i + 1);
            chk("t1_aempty", ae[0], i < 2);
            chk("t1_afull", af[0], i >= 5);
            chk("t1_full", ful[0], i == 7);
        end
        drive(0, 1'b1, 8'h99, 1'b0);
        chk("t1_ovf_hi", ovf[0], 1);
        chk("t1_ovf_cnt", fc0, 8);
        drive(0, 1'b0, 8'h00, 1'b0);
        chk("t1_ovf_lo", ovf[0], 0);

        // Drain in order, then one read too many
        for (int i = 0; i < 8; i++) pop_chk(0, "t2_data", 8'(8'h11 * (i + 1)));
        chk("t2_empty", emp[0], 1);
        drive(0, 1'b0, 8'h00, 1'b1);
        chk("t2_unf_hi", unf[0], 1);
`ifndef SYNC_FIFO_FWFT_EN
        chk("t2_hold", dout[0], 8'h88);
`endif
        drive(0, 1'b0, 8'h00, 1'b0);
        chk("t2_unf_lo", unf[0], 0);

        // Simultaneous read/write while full
        for (int i = 0; i < 8; i++) drive(0, 1'b1, 8'(8'h11 * (i + 1)), 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, 8'(8'hA0 + i), 1'b1);
            chk("t3_no_ovf", ovf[0], 0);
            chk("t3_count", fc0, 8);
        end
        for (int i = 0; i < 4; i++) pop_chk(0, "t3_old", 8'(8'h55 + 8'h11 * i));
        for (int i = 0; i < 4; i++) pop_chk(0, "t3_new", 8'(8'hA0 + i));

        // Depth-5 wrap: 12 write/read pairs
        for (int i = 0; i < 12; i++) begin
            drive(1, 1'b1, 8'(8'h30 + i), 1'b0);
            pop_chk(1, "t4_data", 8'(8'h30 + i));
            chk("t4_unf", unf[1], 0);
        end

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 3; i++) drive(0, 1'b1, 8'(8'hC0 + i), 1'b0);
        chk("t5_pre_count", fc0, 3);
        wr[0]  = 1'b1;
        din[0] = 8'hC3;
        #2;
        rst_n = 1'b0;
        #1;
        reset_lits("t5_async");
        @(negedge clk);
        wr = '0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b1, 8'h3C, 1'b0);
        pop_chk(0, "t5_data", 8'h3C);

`ifdef SYNC_FIFO_FWFT_EN
        drive(0, 1'b1, 8'h5A, 1'b0);
        chk("t6_empty", emp[0], 0);
        chk("t6_dout", dout[0], 8'h5A);
        drive(0, 1'b0, 8'h00, 1'b1);
        chk("t6_empty_after", emp[0], 1);
`endif

        // Randomised traffic, bias cycling write-heavy / balanced / read-heavy
        for (int c = 0; c < 3000; c++) begin
            int pw;
            pw = ((c / 150) % 3 == 0) ? 75 : (((c / 150) % 3 == 1) ? 50 : 25);
            for (int k = 0; k < 2; k++) begin
                wr[k]  = ($urandom_range(99) < pw);
                rd[k]  = ($urandom_range(99) < (100 - pw));
                din[k] = 8'($urandom);
            end
            @(negedge clk);
        end
        wr = '0;
        rd = '0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
